// File: rtl/layer_serializer_if.sv
// Handshake/data bundle between an upstream layer, the serializer and its downstream consumer.
interface layer_serializer_if #(
    parameter int unsigned NN = 30,
    parameter int unsigned DW = 16
);
    localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;

    logic [NN-1:0]    in_valid;
    logic [NN*DW-1:0] in_data;
    logic             out_ready;
    logic             clr_ovf;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_last;
    logic [IW-1:0]    out_index;
    logic             busy;
    logic             overflow;

    modport master (
        output in_valid, in_data, out_ready, clr_ovf,
        input  out_data, out_valid, out_last, out_index, busy, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_ovf,
        output out_data, out_valid, out_last, out_index, busy, overflow
    );
endinterface

// File: rtl/layer_serializer.sv
// Captures a full layer output vector on the rising edge of all-valid and streams it out
// one word at a time, with optional idle gaps and a one-deep pending buffer.
module layer_serializer #(
    parameter int unsigned NN        = 30,
    parameter int unsigned DW        = 16,
    parameter int unsigned GAP       = 5,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    layer_serializer_if.slave bus
);
    localparam int unsigned IW     = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned GW     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned VW     = NN * DW;
    localparam int unsigned GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [IW-1:0] LAST_CNT = IW'(NN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    state, state_d;
    logic [IW-1:0] cnt, cnt_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [VW-1:0] hold, hold_d;
    logic [VW-1:0] pend, pend_d;
    logic          pend_full, pend_full_d;
    logic          av_q;
    logic          ovf_d;

    logic all_valid, cap, hs, last_hs, pend_to_hold, direct_load;

    // Map emission order to a channel number, then select that channel's word.
    function automatic logic [IW-1:0] chan_of(input logic [IW-1:0] c);
        return LSB_FIRST ? c : LAST_CNT - c;
    endfunction

    function automatic logic [DW-1:0] pick_word(input logic [VW-1:0] v, input logic [IW-1:0] c);
        logic [DW-1:0] w;
        logic [IW-1:0] ch;
        w  = '0;
        ch = chan_of(c);
        for (int k = 0; k < int'(NN); k++) begin
            if (ch == IW'(k)) w = v[k*DW +: DW];
        end
        return w;
    endfunction

    assign all_valid    = &bus.in_valid;
    assign cap          = all_valid & ~av_q;
    assign hs           = bus.out_valid & bus.out_ready;
    assign last_hs      = hs & (cnt == LAST_CNT);
    assign pend_to_hold = last_hs & pend_full;
    assign direct_load  = last_hs & ~pend_full & cap;

    // Next-state logic
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        gap_d       = gap_cnt;
        hold_d      = hold;
        pend_d      = pend;
        pend_full_d = pend_full;
        ovf_d       = bus.overflow & ~bus.clr_ovf;

        case (state)
            S_IDLE: begin
                if (cap) begin
                    hold_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (last_hs) begin
                    if (pend_full) begin
                        hold_d      = pend;
                        cnt_d       = '0;
                        pend_full_d = 1'b0;
                        gap_d       = GW'(GAP_M1);
                        state_d     = (GAP > 0) ? S_GAP : S_SEND;
                    end else if (cap) begin
                        hold_d  = bus.in_data;
                        cnt_d   = '0;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (hs) begin
                    cnt_d   = cnt + IW'(1);
                    gap_d   = GW'(GAP_M1);
                    state_d = (GAP > 0) ? S_GAP : S_SEND;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_d = S_SEND;
                else               gap_d   = gap_cnt - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // A vector arriving while busy is parked, unless the single slot is still occupied.
        if (cap && (state != S_IDLE) && !direct_load) begin
            if (!pend_full || pend_to_hold) begin
                pend_d      = bus.in_data;
                pend_full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            gap_cnt       <= '0;
            hold          <= '0;
            pend          <= '0;
            pend_full     <= 1'b0;
            av_q          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_index <= '0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            gap_cnt       <= gap_d;
            hold          <= hold_d;
            pend          <= pend_d;
            pend_full     <= pend_full_d;
            av_q          <= all_valid;
            bus.out_valid <= (state_d == S_SEND);
            bus.out_last  <= (state_d == S_SEND) && (cnt_d == LAST_CNT);
            bus.out_index <= chan_of(cnt_d);
            bus.out_data  <= pick_word(hold_d, cnt_d);
            bus.busy      <= (state_d != S_IDLE) || pend_full_d;
            bus.overflow  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench: instance A (NN=4, GAP=2, LSB first) and instance B (NN=3, GAP=0, MSB first).
module tb_layer_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  i;
        logic        l;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    layer_serializer_if #(.NN(4), .DW(16)) if_a ();
    layer_serializer_if #(.NN(3), .DW(16)) if_b ();

    layer_serializer #(.NN(4), .DW(16), .GAP(2), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .bus(if_a.slave)
    );
    layer_serializer #(.NN(3), .DW(16), .GAP(0), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .bus(if_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards: every accepted word must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && if_a.out_valid && if_a.out_ready) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_word unexpected: got d=%h i=%0d l=%0b, required none", if_a.out_data, if_a.out_index, if_a.out_last);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if ({if_a.out_data, if_a.out_index, if_a.out_last} !== e) begin
                    bad++;
                    $display("FAIL a_word: got d=%h i=%0d l=%0b, required d=%h i=%0d l=%0b",
                             if_a.out_data, if_a.out_index, if_a.out_last, e.d, e.i, e.l);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if_b.out_valid && if_b.out_ready) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_word unexpected: got d=%h i=%0d l=%0b, required none", if_b.out_data, if_b.out_index, if_b.out_last);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if ({if_b.out_data, if_b.out_index, if_b.out_last} !== e) begin
                    bad++;
                    $display("FAIL b_word: got d=%h i=%0d l=%0b, required d=%h i=%0d l=%0b",
                             if_b.out_data, if_b.out_index, if_b.out_last, e.d, e.i, e.l);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push_a(input logic [63:0] v);
        for (int k = 0; k < 4; k++) qa.push_back('{d: v[k*16 +: 16], i: 2'(k), l: (k == 3)});
    endtask

    task automatic drive_a(input logic [63:0] v);
        @(posedge clk); #1;
        if_a.in_data  = v;
        if_a.in_valid = '1;
    endtask

    task automatic drop_a();
        @(posedge clk); #1;
        if_a.in_valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({if_a.out_valid, if_a.busy, if_a.overflow, if_a.out_last, if_a.out_index, if_a.out_data} !== '0) begin
            bad++;
            $display("FAIL reset_a: got v=%0b b=%0b o=%0b l=%0b i=%0d d=%h, required all 0",
                     if_a.out_valid, if_a.busy, if_a.overflow, if_a.out_last, if_a.out_index, if_a.out_data);
        end
        total++;
        if ({if_b.out_valid, if_b.busy, if_b.overflow, if_b.out_last, if_b.out_index, if_b.out_data} !== '0) begin
            bad++;
            $display("FAIL reset_b: got v=%0b b=%0b o=%0b, required all 0", if_b.out_valid, if_b.busy, if_b.overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic exp_v;
        push_a(64'h0004_0003_0002_0001);
        drive_a(64'h0004_0003_0002_0001);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_v = (k == 1) || (k == 4) || (k == 7) || (k == 10);
            total++;
            if (if_a.out_valid !== exp_v) begin
                bad++;
                $display("FAIL single_timing c+%0d: got out_valid=%0b, required %0b", k, if_a.out_valid, exp_v);
            end
        end
        total++;
        if (if_a.busy !== 1'b0 || qa.size() != 0) begin
            bad++;
            $display("FAIL single_idle: got busy=%0b left=%0d, required busy=0 left=0", if_a.busy, qa.size());
        end
        drop_a();
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        bit          seen;
        push_a(64'h0008_0007_0006_0005);
        drive_a(64'h0008_0007_0006_0005);
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (if_a.out_valid && if_a.out_ready && if_a.out_index == 2'd0) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL bp_word1: got no word 1, required word 1"); end
        @(posedge clk); #1;
        if_a.out_ready = 1'b0;
        if_a.in_valid  = '0;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (if_a.out_valid) seen = 1;
        end
        held = if_a.out_data;
        total++;
        if (!seen || held !== 16'h0006) begin
            bad++;
            $display("FAIL bp_word2: got valid=%0b d=%h, required valid=1 d=0006", seen, held);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if (if_a.out_valid !== 1'b1 || if_a.out_data !== held || if_a.out_index !== 2'd1) begin
                bad++;
                $display("FAIL bp_stable %0d: got v=%0b d=%h i=%0d, required v=1 d=%h i=1", k, if_a.out_valid, if_a.out_data, if_a.out_index, held);
            end
        end
        @(posedge clk); #1;
        if_a.out_ready = 1'b1;
        seen = 0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (!if_a.busy) seen = 1;
        end
        total++;
        if (!seen || qa.size() != 0) begin
            bad++;
            $display("FAIL bp_drain: got idle=%0b left=%0d, required idle=1 left=0", seen, qa.size());
        end
    endtask

    task automatic test_pending();
        int t_last, t_next;
        bit done;
        push_a(64'h0014_0013_0012_0011);
        push_a(64'h0024_0023_0022_0021);
        drive_a(64'h0014_0013_0012_0011);
        drop_a();
        drive_a(64'h0024_0023_0022_0021);
        drop_a();
        drive_a(64'h0034_0033_0032_0031);
        drop_a();
        @(negedge clk);
        total++;
        if (if_a.overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: got overflow=%0b, required 1", if_a.overflow);
        end
        t_last = -1; t_next = -1; done = 0;
        for (int t = 0; t < 40 && !done; t++) begin
            if (t > 0) @(negedge clk);
            if (if_a.out_valid && if_a.out_ready) begin
                if (t_last < 0 && if_a.out_last) t_last = cyc;
                else if (t_last >= 0 && t_next < 0) t_next = cyc;
            end
            if (t_next >= 0 && !if_a.busy) done = 1;
        end
        total++;
        if (t_last < 0 || t_next - t_last != 3) begin
            bad++;
            $display("FAIL pend_gap: got spacing=%0d, required 3", t_next - t_last);
        end
        total++;
        if (!done || qa.size() != 0 || if_a.overflow !== 1'b1) begin
            bad++;
            $display("FAIL pend_drain: got idle=%0b left=%0d ovf=%0b, required 1 0 1", done, qa.size(), if_a.overflow);
        end
        @(posedge clk); #1;
        if_a.clr_ovf = 1'b1;
        @(posedge clk); #1;
        if_a.clr_ovf = 1'b0;
        @(negedge clk);
        total++;
        if (if_a.overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clr: got overflow=%0b, required 0", if_a.overflow);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        int noisy;
        push_a(64'h0044_0043_0042_0041);
        push_a(64'h0054_0053_0052_0051);
        drive_a(64'h0044_0043_0042_0041);
        drop_a();
        drive_a(64'h0054_0053_0052_0051);
        drop_a();
        drive_a(64'h0064_0063_0062_0061);
        drop_a();
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (if_a.out_valid && if_a.out_index == 2'd2) seen = 1;
        end
        total++;
        if (!seen || if_a.overflow !== 1'b1 || if_a.busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: got word3=%0b ovf=%0b busy=%0b, required 1 1 1", seen, if_a.overflow, if_a.busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (if_a.out_valid !== 1'b0 || if_a.busy !== 1'b0 || if_a.overflow !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got v=%0b b=%0b o=%0b, required 0 0 0", if_a.out_valid, if_a.busy, if_a.overflow);
        end
        qa.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        noisy = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (if_a.out_valid || if_a.busy) noisy++;
        end
        total++;
        if (noisy != 0) begin
            bad++;
            $display("FAIL rst_no_resume: got %0d active cycles, required 0", noisy);
        end
    endtask

    task automatic test_gap0_msb();
        logic [15:0] wd [3];
        logic [1:0]  wi [3];
        int noisy;
        wd[0] = 16'hC2C2; wd[1] = 16'hB1B1; wd[2] = 16'hA0A0;
        wi[0] = 2'd2;     wi[1] = 2'd1;     wi[2] = 2'd0;
        for (int k = 0; k < 3; k++) qb.push_back('{d: wd[k], i: wi[k], l: (k == 2)});
        @(posedge clk); #1;
        if_b.in_data  = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        if_b.in_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (k >= 1 && k <= 3) begin
                if (if_b.out_valid !== 1'b1 || if_b.out_data !== wd[k-1] || if_b.out_index !== wi[k-1] || if_b.out_last !== (k == 3)) begin
                    bad++;
                    $display("FAIL msb_word c+%0d: got v=%0b d=%h i=%0d l=%0b, required v=1 d=%h i=%0d l=%0b",
                             k, if_b.out_valid, if_b.out_data, if_b.out_index, if_b.out_last, wd[k-1], wi[k-1], (k == 3));
                end
            end else if (if_b.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL msb_idle c+%0d: got out_valid=%0b, required 0", k, if_b.out_valid);
            end
        end
        noisy = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (if_b.out_valid || if_b.busy) noisy++;
        end
        total++;
        if (noisy != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL msb_no_recapture: got %0d active cycles left=%0d, required 0 0", noisy, qb.size());
        end
        @(posedge clk); #1;
        if_b.in_valid = '0;
    endtask

    initial begin
        if_a.in_valid = '0; if_a.in_data = '0; if_a.out_ready = 1'b1; if_a.clr_ovf = 1'b0;
        if_b.in_valid = '0; if_b.in_data = '0; if_b.out_ready = 1'b1; if_b.clr_ovf = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_pending();
        test_async_reset();
        test_gap0_msb();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
